// File: rtl/accelerator_write_vector_heads.sv
// Write-head vector stage: streams N x W elements (k inner, j outer) with a
// 1-entry output register, (j,k) index tags and a per-run copy/erase/negate transform.
module accelerator_write_vector_heads #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [1:0]              MODE_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_N_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_W_IN,
    input  logic                    V_IN_ENABLE,
    output logic                    V_IN_READY,
    input  logic [DATA_SIZE-1:0]    V_IN,
    output logic                    V_OUT_ENABLE,
    input  logic                    V_OUT_READY,
    output logic [DATA_SIZE-1:0]    V_OUT,
    output logic [CONTROL_SIZE-1:0] J_OUT,
    output logic [CONTROL_SIZE-1:0] K_OUT
);

    // Counters and sizes are compared at the wider of the two widths, zero-extended.
    localparam int unsigned CMP_W = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;

    localparam logic [1:0] M_ERASE  = 2'b01;
    localparam logic [1:0] M_NEGATE = 2'b10;

    logic [1:0]              state_q, state_d;
    logic [DATA_SIZE-1:0]    n_q, n_d;
    logic [DATA_SIZE-1:0]    w_q, w_d;
    logic [1:0]              mode_q, mode_d;
    logic [CONTROL_SIZE-1:0] index_j_q, index_j_d;
    logic [CONTROL_SIZE-1:0] index_k_q, index_k_d;
    logic [DATA_SIZE-1:0]    v_out_q, v_out_d;
    logic [CONTROL_SIZE-1:0] j_out_q, j_out_d;
    logic [CONTROL_SIZE-1:0] k_out_q, k_out_d;
    logic                    v_out_enable_q, v_out_enable_d;
    logic                    ready_q, ready_d;

    logic                    in_ready_c;
    logic                    accept_c;
    logic                    drain_c;
    logic                    last_k_c;
    logic                    last_j_c;
    logic [DATA_SIZE-1:0]    xform_c;

    // Next-state, handshake and datapath logic.
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        w_d            = w_q;
        mode_d         = mode_q;
        index_j_d      = index_j_q;
        index_k_d      = index_k_q;
        v_out_d        = v_out_q;
        j_out_d        = j_out_q;
        k_out_d        = k_out_q;
        v_out_enable_d = v_out_enable_q;
        ready_d        = 1'b0;

        in_ready_c = (state_q == S_RUN) && (!v_out_enable_q || V_OUT_READY);
        accept_c   = in_ready_c && V_IN_ENABLE;
        drain_c    = v_out_enable_q && V_OUT_READY;
        last_k_c   = (CMP_W'(index_k_q) == CMP_W'(w_q - DATA_SIZE'(1)));
        last_j_c   = (CMP_W'(index_j_q) == CMP_W'(n_q - DATA_SIZE'(1)));

        case (mode_q)
            M_ERASE:  xform_c = '0;
            M_NEGATE: xform_c = DATA_SIZE'(0) - V_IN;
            default:  xform_c = V_IN;
        endcase

        if (drain_c) begin
            v_out_enable_d = 1'b0;
        end

        // An accept may coincide with a drain; the new element replaces the old one.
        if (accept_c) begin
            v_out_d        = xform_c;
            j_out_d        = index_j_q;
            k_out_d        = index_k_q;
            v_out_enable_d = 1'b1;
            if (last_k_c) begin
                index_k_d = '0;
                index_j_d = index_j_q + CONTROL_SIZE'(1);
            end else begin
                index_k_d = index_k_q + CONTROL_SIZE'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    n_d       = SIZE_N_IN;
                    w_d       = SIZE_W_IN;
                    mode_d    = MODE_IN;
                    index_j_d = '0;
                    index_k_d = '0;
                    if ((SIZE_N_IN == '0) || (SIZE_W_IN == '0)) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept_c && last_j_c && last_k_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_c) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            w_q            <= '0;
            mode_q         <= '0;
            index_j_q      <= '0;
            index_k_q      <= '0;
            v_out_q        <= '0;
            j_out_q        <= '0;
            k_out_q        <= '0;
            v_out_enable_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            w_q            <= w_d;
            mode_q         <= mode_d;
            index_j_q      <= index_j_d;
            index_k_q      <= index_k_d;
            v_out_q        <= v_out_d;
            j_out_q        <= j_out_d;
            k_out_q        <= k_out_d;
            v_out_enable_q <= v_out_enable_d;
            ready_q        <= ready_d;
        end
    end

    assign READY        = ready_q;
    assign V_IN_READY   = in_ready_c;
    assign V_OUT_ENABLE = v_out_enable_q;
    assign V_OUT        = v_out_q;
    assign J_OUT        = j_out_q;
    assign K_OUT        = k_out_q;

endmodule

// File: tb/tb_accelerator_write_vector_heads.sv
// Directed bench for accelerator_write_vector_heads with an output scoreboard.
module tb_accelerator_write_vector_heads;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready;
    logic [1:0]    mode_in = 2'b00;
    logic [DW-1:0] size_n = '0;
    logic [DW-1:0] size_w = '0;
    logic          v_in_enable = 1'b0;
    logic          v_in_ready;
    logic [DW-1:0] v_in = '0;
    logic          v_out_enable;
    logic          v_out_ready = 1'b1;
    logic [DW-1:0] v_out;
    logic [CW-1:0] j_out;
    logic [CW-1:0] k_out;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] j;
        logic [CW-1:0] k;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   out_cnt = 0;
    int   ready_cnt = 0;
    bit   tog_en = 1'b0;

    accelerator_write_vector_heads #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .START        (start),
        .READY        (ready),
        .MODE_IN      (mode_in),
        .SIZE_N_IN    (size_n),
        .SIZE_W_IN    (size_w),
        .V_IN_ENABLE  (v_in_enable),
        .V_IN_READY   (v_in_ready),
        .V_IN         (v_in),
        .V_OUT_ENABLE (v_out_enable),
        .V_OUT_READY  (v_out_ready),
        .V_OUT        (v_out),
        .J_OUT        (j_out),
        .K_OUT        (k_out)
    );

    initial forever #5 clk = ~clk;

    // Downstream ready: constant 1, or toggling every cycle when tog_en is set.
    initial forever begin
        @(posedge clk);
        #1;
        v_out_ready = tog_en ? ~v_out_ready : 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] v);
        case (m)
            2'b01:   return '0;
            2'b10:   return ~v + DW'(1);
            default: return v;
        endcase
    endfunction

    // Output monitor: pop and compare each element that leaves the DUT.
    always @(negedge clk) begin
        exp_t e;
        if (v_out_enable === 1'b1) begin
            if (v_out_ready) begin
                out_cnt++;
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("v_out", v_out, e.d);
                    check("j_out", j_out, e.j);
                    check("k_out", k_out, e.k);
                end
            end else begin
                check("in_ready_while_stalled", 64'(v_in_ready), 64'd0);
            end
        end
        if (ready === 1'b1) begin
            ready_cnt++;
            check("ready_with_pending", 64'(v_out_enable), 64'd0);
        end
    end

    // Called at posedge+1; START is sampled on the next edge.
    task automatic start_run(input logic [DW-1:0] n, input logic [DW-1:0] w, input logic [1:0] m);
        start   = 1'b1;
        size_n  = n;
        size_w  = w;
        mode_in = m;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one element, record its expectation, wait (bounded) for acceptance.
    task automatic feed(input logic [DW-1:0] v, input logic [1:0] m, input int j, input int k,
                        output int stalls);
        exp_t e;
        bit   got;
        e.d = model(m, v);
        e.j = CW'(j);
        e.k = CW'(k);
        sb.push_back(e);
        v_in        = v;
        v_in_enable = 1'b1;
        stalls      = 0;
        got         = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (v_in_ready) begin
                got = 1'b1;
                break;
            end
            stalls++;
        end
        check("accept_in_time", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        v_in_enable = 1'b0;
    endtask

    // Wait (bounded) for READY, return cycles waited, end at posedge+1.
    task automatic wait_ready(input string tag, output int cyc);
        cyc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ready) break;
            cyc++;
        end
        check(tag, 64'(ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int tot;
        int cyc;
        int base;
        int rbase;
        logic [DW-1:0] vals[4];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_v_in_ready", 64'(v_in_ready), 64'd0);
        check("rst_v_out_enable", 64'(v_out_enable), 64'd0);
        check("rst_v_out", v_out, 64'd0);
        check("rst_j_out", j_out, 64'd0);
        check("rst_k_out", k_out, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: N=2, W=3, copy, full throughput
        base = out_cnt;
        tot  = 0;
        start_run(DW'(2), DW'(3), 2'b00);
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 3; k++) begin
                feed(DW'(j * 3 + k + 1), 2'b00, j, k, st);
                tot += st;
            end
        end
        check("t1_no_stalls", 64'(tot), 64'd0);
        wait_ready("t1_ready", cyc);
        check("t1_ready_latency", 64'(cyc), 64'd1);
        check("t1_ready_one_pulse", 64'(ready), 64'd0);
        check("t1_out_count", 64'(out_cnt - base), 64'd6);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: N=1, W=4, negate
        vals[0] = DW'(5);
        vals[1] = '0;
        vals[2] = '1;
        vals[3] = {1'b1, {(DW-1){1'b0}}};
        start_run(DW'(1), DW'(4), 2'b10);
        for (int k = 0; k < 4; k++) feed(vals[k], 2'b10, 0, k, st);
        wait_ready("t2_ready", cyc);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // 3: N=1, W=4, erase with toggling downstream ready
        base   = out_cnt;
        tog_en = 1'b1;
        start_run(DW'(1), DW'(4), 2'b01);
        for (int k = 0; k < 4; k++) feed(DW'(100 + k), 2'b01, 0, k, st);
        wait_ready("t3_ready", cyc);
        tog_en = 1'b0;
        check("t3_out_count", 64'(out_cnt - base), 64'd4);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // 4: empty runs complete immediately
        base = out_cnt;
        start_run(DW'(5), DW'(0), 2'b00);
        check("t4_w0_ready", 64'(ready), 64'd1);
        check("t4_w0_in_ready", 64'(v_in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t4_w0_ready_drop", 64'(ready), 64'd0);
        start_run(DW'(0), DW'(3), 2'b00);
        check("t4_n0_ready", 64'(ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_output", 64'(out_cnt - base), 64'd0);
        check("t4_v_out_enable", 64'(v_out_enable), 64'd0);

        // 5: START and MODE_IN changes during RUN are ignored
        base = out_cnt;
        start_run(DW'(2), DW'(2), 2'b10);
        feed(DW'(3), 2'b10, 0, 0, st);
        start   = 1'b1;
        mode_in = 2'b01;
        size_n  = DW'(9);
        size_w  = DW'(9);
        feed(DW'(4), 2'b10, 0, 1, st);
        start = 1'b0;
        feed(DW'(5), 2'b10, 1, 0, st);
        feed(DW'(6), 2'b10, 1, 1, st);
        wait_ready("t5_ready", cyc);
        check("t5_out_count", 64'(out_cnt - base), 64'd4);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);
        check("t5_idle_after", 64'(v_in_ready), 64'd0);

        // 6: reset mid-run, then a clean run
        rbase = ready_cnt;
        start_run(DW'(2), DW'(3), 2'b00);
        for (int k = 0; k < 3; k++) feed(DW'(k + 1), 2'b00, 0, k, st);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_v_out_enable", 64'(v_out_enable), 64'd0);
        check("t6_rst_v_out", v_out, 64'd0);
        check("t6_rst_j_out", j_out, 64'd0);
        check("t6_rst_k_out", k_out, 64'd0);
        check("t6_rst_ready", 64'(ready), 64'd0);
        check("t6_rst_in_ready", 64'(v_in_ready), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_ready", 64'(ready_cnt - rbase), 64'd0);
        start_run(DW'(1), DW'(2), 2'b00);
        feed(DW'(10), 2'b00, 0, 0, st);
        feed(DW'(20), 2'b00, 0, 1, st);
        wait_ready("t6_ready", cyc);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
